// File: rtl/ctrl_axi_pkg.sv
// Shared register map, CTRL bit positions and read-FSM states for the
// ctrl_axi_slave AXI4-Lite control block.
package ctrl_axi_pkg;

  localparam int CTRL_ADDR = 'h00;
  localparam int ARG_BASE  = 'h10;

  localparam int CTRL_START_BIT        = 0;
  localparam int CTRL_DONE_BIT         = 1;
  localparam int CTRL_IDLE_BIT         = 2;
  localparam int CTRL_READY_BIT        = 3;
  localparam int CTRL_AUTO_RESTART_BIT = 7;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Byte-lane merge of a 32-bit register with new write data.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ctrl_axi_slave.sv
// AXI4-Lite slave exposing an ap_ctrl handshake register and NUM_ARGS
// argument registers to the host bridge.
module ctrl_axi_slave
  import ctrl_axi_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = DATA_BITS / 8,
  parameter int NUM_ARGS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   s_axi_control_AWVALID,
  output logic                   s_axi_control_AWREADY,
  input  logic [ADDR_BITS-1:0]   s_axi_control_AWADDR,

  input  logic                   s_axi_control_WVALID,
  output logic                   s_axi_control_WREADY,
  input  logic [DATA_BITS-1:0]   s_axi_control_WDATA,
  input  logic [STRB_BITS-1:0]   s_axi_control_WSTRB,

  output logic                   s_axi_control_BVALID,
  input  logic                   s_axi_control_BREADY,
  output logic [1:0]             s_axi_control_BRESP,

  input  logic                   s_axi_control_ARVALID,
  output logic                   s_axi_control_ARREADY,
  input  logic [ADDR_BITS-1:0]   s_axi_control_ARADDR,

  output logic                   s_axi_control_RVALID,
  input  logic                   s_axi_control_RREADY,
  output logic [DATA_BITS-1:0]   s_axi_control_RDATA,
  output logic [1:0]             s_axi_control_RRESP,

  output logic                   ap_start,
  input  logic                   ap_done,
  input  logic                   ap_idle,
  input  logic                   ap_ready,

  output logic [NUM_ARGS*32-1:0] args
);

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam logic [WORD_BITS-1:0] CTRL_WORD = WORD_BITS'(CTRL_ADDR / 4);

  logic                 aw_full_q, aw_full_d;
  logic [WORD_BITS-1:0] aw_word_q, aw_word_d;
  logic                 w_full_q, w_full_d;
  logic [DATA_BITS-1:0] w_data_q, w_data_d;
  logic [STRB_BITS-1:0] w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d;

  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 auto_q, auto_d;
  logic [DATA_BITS-1:0] arg_q [NUM_ARGS];
  logic [DATA_BITS-1:0] arg_d [NUM_ARGS];

  rd_state_t            rd_state_q, rd_state_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  logic                 aw_hs, w_hs, commit, ar_hs;
  logic [WORD_BITS-1:0] ar_word;
  logic [DATA_BITS-1:0] ctrl_rd, rd_mux;
  logic                 unused_addr_lsbs;

  assign s_axi_control_AWREADY = !aw_full_q && !bvalid_q;
  assign s_axi_control_WREADY  = !w_full_q && !bvalid_q;
  assign s_axi_control_BVALID  = bvalid_q;
  assign s_axi_control_BRESP   = 2'b00;
  assign s_axi_control_ARREADY = (rd_state_q == RD_IDLE);
  assign s_axi_control_RVALID  = (rd_state_q == RD_DATA);
  assign s_axi_control_RDATA   = rdata_q;
  assign s_axi_control_RRESP   = 2'b00;
  assign ap_start              = start_q;

  assign aw_hs   = s_axi_control_AWVALID && s_axi_control_AWREADY;
  assign w_hs    = s_axi_control_WVALID && s_axi_control_WREADY;
  assign commit  = aw_full_q && w_full_q;
  assign ar_hs   = s_axi_control_ARVALID && s_axi_control_ARREADY;
  assign ar_word = s_axi_control_ARADDR[ADDR_BITS-1:2];

  assign unused_addr_lsbs = ^{s_axi_control_AWADDR[1:0], s_axi_control_ARADDR[1:0]};

  for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
    assign args[32*g +: 32] = arg_q[g];
  end

  // Write holders fill independently; both full means the write commits now.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_word_d = aw_word_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_word_d = s_axi_control_AWADDR[ADDR_BITS-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axi_control_WDATA;
      w_strb_d = s_axi_control_WSTRB;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end
    if (bvalid_q && s_axi_control_BREADY) bvalid_d = 1'b0;
  end

  // Ordering gives the priorities: host start write beats ap_ready, done pulse beats read-clear.
  always_comb begin
    start_d = start_q;
    done_d  = done_q;
    auto_d  = auto_q;
    for (int i = 0; i < NUM_ARGS; i++) arg_d[i] = arg_q[i];

    if (ap_ready && !auto_q) start_d = 1'b0;
    if (ar_hs && ar_word == CTRL_WORD) done_d = 1'b0;
    if (ap_done) done_d = 1'b1;

    if (commit) begin
      if (aw_word_q == CTRL_WORD && w_strb_q[0]) begin
        if (w_data_q[CTRL_START_BIT]) start_d = 1'b1;
        auto_d = w_data_q[CTRL_AUTO_RESTART_BIT];
      end
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (aw_word_q == WORD_BITS'(ARG_BASE / 4 + i))
          arg_d[i] = apply_strb(arg_q[i], w_data_q, w_strb_q);
      end
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_START_BIT]        = start_q;
    ctrl_rd[CTRL_DONE_BIT]         = done_q;
    ctrl_rd[CTRL_IDLE_BIT]         = ap_idle;
    ctrl_rd[CTRL_READY_BIT]        = 1'b0;
    ctrl_rd[CTRL_AUTO_RESTART_BIT] = auto_q;

    rd_mux = '0;
    if (ar_word == CTRL_WORD) rd_mux = ctrl_rd;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (ar_word == WORD_BITS'(ARG_BASE / 4 + i)) rd_mux = arg_q[i];
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_control_ARVALID) begin
          rdata_d    = rd_mux;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi_control_RREADY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_full_q  <= 1'b0;
      aw_word_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      auto_q     <= 1'b0;
      for (int i = 0; i < NUM_ARGS; i++) arg_q[i] <= '0;
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
    end else begin
      aw_full_q  <= aw_full_d;
      aw_word_q  <= aw_word_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      start_q    <= start_d;
      done_q     <= done_d;
      auto_q     <= auto_d;
      for (int i = 0; i < NUM_ARGS; i++) arg_q[i] <= arg_d[i];
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ctrl_axi_slave.sv
// Directed bench for ctrl_axi_slave: register map, write/read latency,
// ap_ctrl handshake and its collision cases.
module tb_ctrl_axi_slave;

  logic         clock = 1'b0;
  logic         reset;
  logic         AWVALID, AWREADY;
  logic [5:0]   AWADDR;
  logic         WVALID, WREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         BVALID, BREADY;
  logic [1:0]   BRESP;
  logic         ARVALID, ARREADY;
  logic [5:0]   ARADDR;
  logic         RVALID, RREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         ap_start, ap_done, ap_idle, ap_ready;
  logic [127:0] args;

  int           checks = 0;
  int           errors = 0;
  int           lat;
  logic [31:0]  rd;
  logic [127:0] expArgs;

  always #5 clock = ~clock;

  ctrl_axi_slave dut (
    .clock(clock), .reset(reset),
    .s_axi_control_AWVALID(AWVALID), .s_axi_control_AWREADY(AWREADY), .s_axi_control_AWADDR(AWADDR),
    .s_axi_control_WVALID(WVALID), .s_axi_control_WREADY(WREADY),
    .s_axi_control_WDATA(WDATA), .s_axi_control_WSTRB(WSTRB),
    .s_axi_control_BVALID(BVALID), .s_axi_control_BREADY(BREADY), .s_axi_control_BRESP(BRESP),
    .s_axi_control_ARVALID(ARVALID), .s_axi_control_ARREADY(ARREADY), .s_axi_control_ARADDR(ARADDR),
    .s_axi_control_RVALID(RVALID), .s_axi_control_RREADY(RREADY),
    .s_axi_control_RDATA(RDATA), .s_axi_control_RRESP(RRESP),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .args(args)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  // order: 0 = AW and W together, 1 = AW then W, 2 = W then AW.
  // readyCycle: cycle (relative to first VALID) in which ap_ready is pulsed, -1 for none.
  task automatic axiWrite(input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int order, input int holdCycles,
                          input int readyCycle, output int latency);
    logic awHs, wHs;
    AWADDR   = addr;
    WDATA    = data;
    WSTRB    = strb;
    AWVALID  = (order != 2);
    WVALID   = (order != 1);
    ap_ready = (readyCycle == 0);
    latency  = 0;
    while (!BVALID && latency < 20) begin
      awHs = AWVALID && AWREADY;
      wHs  = WVALID && WREADY;
      @(posedge clock); #1;
      latency++;
      ap_ready = (readyCycle == latency);
      if (awHs) begin
        AWVALID = 1'b0;
        if (order == 1) WVALID = 1'b1;
      end
      if (wHs) begin
        WVALID = 1'b0;
        if (order == 2) AWVALID = 1'b1;
      end
    end
    AWVALID  = 1'b0;
    WVALID   = 1'b0;
    ap_ready = 1'b0;
    checkOutput("bresp", {126'd0, BRESP}, 128'd0);
    for (int k = 0; k < holdCycles; k++) begin
      @(posedge clock); #1;
      checkOutput("awready_hold", {127'd0, AWREADY}, 128'd0);
      checkOutput("wready_hold", {127'd0, WREADY}, 128'd0);
      checkOutput("bvalid_hold", {127'd0, BVALID}, 128'd1);
    end
    BREADY = 1'b1;
    @(posedge clock); #1;
    BREADY = 1'b0;
    checkOutput("bvalid_clear", {127'd0, BVALID}, 128'd0);
  endtask

  task automatic axiRead(input logic [5:0] addr, input logic pulseDone,
                         output logic [31:0] data, output int latency);
    logic arHs;
    ARADDR  = addr;
    ARVALID = 1'b1;
    ap_done = pulseDone;
    latency = 0;
    while (!RVALID && latency < 20) begin
      arHs = ARVALID && ARREADY;
      @(posedge clock); #1;
      latency++;
      ap_done = 1'b0;
      if (arHs) ARVALID = 1'b0;
    end
    ARVALID = 1'b0;
    data    = RDATA;
    checkOutput("rresp", {126'd0, RRESP}, 128'd0);
    RREADY = 1'b1;
    @(posedge clock); #1;
    RREADY = 1'b0;
    checkOutput("rvalid_clear", {127'd0, RVALID}, 128'd0);
  endtask

  task automatic readExpect(input string tag, input logic [5:0] addr,
                            input logic [31:0] expected);
    logic [31:0] value;
    int          l;
    axiRead(addr, 1'b0, value, l);
    checkOutput({tag, "_data"}, {96'd0, value}, {96'd0, expected});
    checkOutput({tag, "_lat"}, 128'(l), 128'd1);
  endtask

  task automatic pulseReady();
    ap_ready = 1'b1;
    @(posedge clock); #1;
    ap_ready = 1'b0;
  endtask

  task automatic pulseDoneOnly();
    ap_done = 1'b1;
    @(posedge clock); #1;
    ap_done = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    AWVALID = 1'b0; AWADDR = '0;
    WVALID  = 1'b0; WDATA = '0; WSTRB = '0;
    BREADY  = 1'b0;
    ARVALID = 1'b0; ARADDR = '0;
    RREADY  = 1'b0;
    ap_done = 1'b0; ap_idle = 1'b1; ap_ready = 1'b0;
    expArgs = '0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_awready", {127'd0, AWREADY}, 128'd1);
    checkOutput("rst_wready", {127'd0, WREADY}, 128'd1);
    checkOutput("rst_arready", {127'd0, ARREADY}, 128'd1);
    checkOutput("rst_bvalid", {127'd0, BVALID}, 128'd0);
    checkOutput("rst_rvalid", {127'd0, RVALID}, 128'd0);
    checkOutput("rst_rdata", {96'd0, RDATA}, 128'd0);
    checkOutput("rst_resp", {124'd0, BRESP, RRESP}, 128'd0);
    checkOutput("rst_ap_start", {127'd0, ap_start}, 128'd0);
    checkOutput("rst_args", args, 128'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    readExpect("ctrl_after_reset", 6'h00, 32'h4);

    axiWrite(6'h10, 32'hDEADBEEF, 4'hF, 1, 0, -1, lat);
    checkOutput("wr_lat_aw_then_w", 128'(lat), 128'd3);
    expArgs[31:0] = 32'hDEADBEEF;
    checkOutput("arg0", args, expArgs);
    readExpect("arg0_rb", 6'h10, 32'hDEADBEEF);

    axiWrite(6'h14, 32'hFFFFFFFF, 4'hF, 0, 0, -1, lat);
    checkOutput("wr_lat_same_cycle", 128'(lat), 128'd2);
    axiWrite(6'h14, 32'h12345678, 4'h3, 0, 0, -1, lat);
    expArgs[63:32] = 32'hFFFF5678;
    checkOutput("arg1_strb", args, expArgs);
    readExpect("arg1_rb", 6'h17, 32'hFFFF5678);

    axiWrite(6'h1C, 32'hA5A5A5A5, 4'hF, 0, 0, -1, lat);
    expArgs[127:96] = 32'hA5A5A5A5;
    checkOutput("arg3_last", args, expArgs);
    readExpect("past_last_arg", 6'h20, 32'h0);

    ap_idle = 1'b0;
    readExpect("ctrl_not_idle", 6'h00, 32'h0);
    ap_idle = 1'b1;

    axiWrite(6'h00, 32'h00000001, 4'h1, 1, 0, -1, lat);
    checkOutput("start_set", {127'd0, ap_start}, 128'd1);
    readExpect("ctrl_started", 6'h00, 32'h5);
    pulseReady();
    checkOutput("start_drop_on_ready", {127'd0, ap_start}, 128'd0);
    pulseDoneOnly();
    readExpect("ctrl_done_sticky", 6'h00, 32'h6);
    readExpect("ctrl_done_cleared", 6'h00, 32'h4);

    axiWrite(6'h00, 32'h00000081, 4'h1, 1, 0, -1, lat);
    readExpect("ctrl_auto", 6'h00, 32'h85);
    pulseReady();
    checkOutput("start_held_auto", {127'd0, ap_start}, 128'd1);
    axiRead(6'h00, 1'b1, rd, lat);
    checkOutput("done_collide_old", {96'd0, rd}, 128'h85);
    readExpect("done_collide_set", 6'h00, 32'h87);
    readExpect("done_collide_clr", 6'h00, 32'h85);

    axiWrite(6'h00, 32'h00000000, 4'h1, 0, 0, -1, lat);
    checkOutput("write0_keeps_start", {127'd0, ap_start}, 128'd1);
    readExpect("ctrl_auto_off", 6'h00, 32'h5);
    pulseReady();
    checkOutput("start_drop_auto_off", {127'd0, ap_start}, 128'd0);
    axiWrite(6'h00, 32'h00000001, 4'h1, 0, 0, 1, lat);
    checkOutput("start_write_beats_ready", {127'd0, ap_start}, 128'd1);
    pulseReady();
    checkOutput("start_drop_again", {127'd0, ap_start}, 128'd0);

    axiWrite(6'h3C, 32'hCAFEF00D, 4'hF, 2, 5, -1, lat);
    checkOutput("wr_lat_w_then_aw", 128'(lat), 128'd3);
    checkOutput("unmapped_no_change", args, expArgs);
    checkOutput("unmapped_start", {127'd0, ap_start}, 128'd0);
    readExpect("unmapped_read", 6'h3C, 32'h0);
    readExpect("ctrl_final", 6'h00, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_axi_slave.md
# ctrl_axi_slave

AXI4-Lite slave control-register block terminating the `s_axi_control` port driven by the host bridge. It decodes host register reads and writes into an HLS-style `ap_ctrl` handshake to the accelerator core. It also exposes `NUM_ARGS` 32-bit argument registers. It sits between the host bridge and the accelerator datapath.

## Interface
- `ADDR_BITS`, 6: AXI address width; byte addresses, word aligned.
- `DATA_BITS`, 32: AXI data width; fixed at 32.
- `STRB_BITS`, `DATA_BITS/8`: write-strobe width.
- `NUM_ARGS`, 4: argument registers, 1..8.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `s_axi_control_AW{VALID,READY,ADDR}` in/out/in 1/1/`ADDR_BITS`: write-address channel.
- `s_axi_control_W{VALID,READY,DATA,STRB}` in/out/in/in 1/1/`DATA_BITS`/`STRB_BITS`: write-data channel.
- `s_axi_control_B{VALID,READY,RESP}` out/in/out 1/1/2: write response.
- `s_axi_control_AR{VALID,READY,ADDR}` in/out/in 1/1/`ADDR_BITS`: read address.
- `s_axi_control_R{VALID,READY,DATA,RESP}` out/in/out/out 1/1/`DATA_BITS`/2: read data.
- `ap_start` out 1: start level to the core.
- `ap_done` in 1: one-cycle pulse; the core finished.
- `ap_idle` in 1: level; the core is idle.
- `ap_ready` in 1: one-cycle pulse; the core accepted its inputs.
- `args` out `NUM_ARGS*32`: argument registers flattened; argument i is at bits [32i+31:32i].

## Operation
Register map (byte address):
- 0x00 CTRL.
  - bit0 `ap_start`: RW; writing 1 sets it, writing 0 has no effect.
  - bit1 `ap_done`: RO, sticky, cleared on read.
  - bit2 `ap_idle`: RO, live value.
  - bit3 `ap_ready`: RO; reads 0.
  - bit7 `auto_restart`: RW.
  - Other bits read 0.
- 0x10 + 4·i, for i < `NUM_ARGS`: ARG i; RW; byte-wise WSTRB honored.
- Unmapped addresses: writes are accepted and ignored; reads return 0.
- RESP is always 0 (OKAY).
- Address bits [1:0] are ignored.

Write path:
- Holding registers `aw_full` and `w_full`.
- `AWREADY = !aw_full & !BVALID`; `WREADY = !w_full & !BVALID`.
- AW and W are accepted in either order or in the same cycle.
- In the cycle both are full, the write commits at the clock edge, both holders clear, and `BVALID` sets.
- `BVALID` holds until `BREADY`.

Read path: two-state FSM.
- `RD_IDLE`: `ARREADY=1`. An AR handshake captures the read mux into an `rdata` register and moves to `RD_DATA`.
- `RD_DATA`: `RVALID=1`, `ARREADY=0`. An R handshake returns to `RD_IDLE`.
- A CTRL read clears `ap_done` at the AR-handshake edge.

Control behavior:
- `ap_start` clears on `ap_ready` when `auto_restart=0`; it stays set when `auto_restart=1`.
- `ap_done` pulse sets the sticky done bit.

Simultaneous events:
- A CTRL write of start=1 in the same cycle as `ap_ready`: the write wins, so `ap_start` is 1.
- `ap_done` pulse in the same cycle as a CTRL read: the read returns the old value, and the bit ends set. The set wins over clear-on-read.
- A read and a write to the same register at once: the read returns the pre-write value.

Reset: clears every register, both holders and the FSM. A transaction in flight at reset is dropped and produces no response.

## Timing
Reset values:
- `AWREADY`=1, `WREADY`=1, `ARREADY`=1.
- `BVALID`=0, `RVALID`=0.
- BRESP=RESP=0, `RDATA`=0.
- `ap_start`=0, `args`=0.

Write latency:
- AW and W in the same cycle t: commit at the end of t+1; `BVALID` in t+2.
- AW at t, W at t+1 (host-bridge order): `BVALID` in t+3.

Read latency: AR handshake at t gives `RVALID` with data in t+1.

Throughput and handshakes:
- One outstanding write and one outstanding read; the two paths are independent.
- Outputs do not depend combinationally on the matching VALID inputs.
- All VALIDs hold until their READY.

## Structure
- Package `ctrl_axi_pkg`: register offsets (`CTRL_ADDR`, `ARG_BASE`), CTRL bit indices, read-FSM enum `rd_state_t {RD_IDLE, RD_DATA}`.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset, then read 0x00 with `ap_idle`=1 -> RDATA=0x4, RVALID one cycle after AR, RESP=0.
- Write 0x10 = 0xDEADBEEF with AW then W (host-bridge order) -> BVALID 3 cycles after AW; `args[31:0]`=0xDEADBEEF; read-back matches.
- Write 0x14 with WSTRB=0x3, data 0x12345678, over a prior value 0xFFFFFFFF -> `args[63:32]`=0xFFFF5678.
- Write CTRL=0x1, pulse `ap_ready`, then pulse `ap_done`:
  - `ap_start` goes 1 and drops after `ap_ready`.
  - First CTRL read returns bit1=1; second read returns bit1=0.
- `auto_restart` and collision case:
  - CTRL=0x81, then pulse `ap_ready` -> `ap_start` stays 1.
  - `ap_done` pulse in the same cycle as a CTRL AR handshake -> that read shows done=0 and the next read shows done=1.
- W before AW, BREADY held low 5 cycles, write to 0x3C (unmapped) -> AWREADY/WREADY stay low while BVALID is pending; no register changes; BRESP=0.
